// File: rtl/sha_pkg.sv
// Shared types and width helpers for the keypad authentication controller.
package sha_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StChgOld,
        StCheck,
        StChgNew,
        StLockout
    } state_e;

    // Key-code type at the default key width.
    localparam int unsigned KeyW = 4;
    typedef logic [KeyW-1:0] key_code_t;

    // Bits needed to index n items (at least 1).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return idx_w(n + 1);
    endfunction

    // digit_cnt width: counts 0..NUM_DIGITS-1.
    function automatic int unsigned digit_cnt_w(input int unsigned num_digits);
        return idx_w(num_digits);
    endfunction

    // fail_cnt width: counts 0..MAX_ATTEMPTS.
    function automatic int unsigned fail_cnt_w(input int unsigned max_attempts);
        return cnt_w(max_attempts);
    endfunction

    // Shared timer width: must hold the larger of the two reload values.
    function automatic int unsigned timer_w(input int unsigned lockout_cycles,
                                            input int unsigned timeout_cycles);
        return cnt_w((lockout_cycles > timeout_cycles) ? lockout_cycles : timeout_cycles);
    endfunction

endpackage

// File: rtl/sha_keypad_auth_if.sv
// Keypad strobe inputs and status outputs of the authentication controller.
interface sha_keypad_auth_if import sha_pkg::*; #(
    parameter int unsigned KEY_W        = 4,
    parameter int unsigned NUM_USERS    = 2,
    parameter int unsigned MAX_ATTEMPTS = 3
) ();

    localparam int unsigned UserW = idx_w(NUM_USERS);
    localparam int unsigned AttW  = fail_cnt_w(MAX_ATTEMPTS);

    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic [UserW-1:0] user_sel;
    logic             change_mode;

    logic             security_active;
    logic             locked_out;
    logic             buzzer;
    logic             auth_ok;
    logic             auth_fail;
    logic             pw_changed;
    logic [AttW-1:0]  attempts_left;
    logic             busy;

    // Keypad / host side.
    modport master (
        output key_valid, key_code, user_sel, change_mode,
        input  security_active, locked_out, buzzer, auth_ok, auth_fail, pw_changed,
               attempts_left, busy
    );

    // Controller side.
    modport slave (
        input  key_valid, key_code, user_sel, change_mode,
        output security_active, locked_out, buzzer, auth_ok, auth_fail, pw_changed,
               attempts_left, busy
    );

endinterface

// File: rtl/sha_lockout_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
module sha_lockout_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;

    // Load has priority; otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sha_keypad_auth.sv
// Keypad authentication controller: per-user N-digit codes checked one digit per key,
// arm toggle on success, lockout after repeated failures, verified password change.
// Optional build macro INTER_KEY_TIMEOUT_EN aborts a stalled partial entry.
module sha_keypad_auth import sha_pkg::*; #(
    parameter int unsigned NUM_DIGITS     = 10,
    parameter int unsigned KEY_W          = 4,
    parameter int unsigned NUM_USERS      = 2,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 30_000_000,
    parameter logic [NUM_USERS*NUM_DIGITS*KEY_W-1:0] DEFAULT_PW = {NUM_USERS{40'h123456789A}},
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    sha_keypad_auth_if.slave   kp
);

    localparam int unsigned DigitW = digit_cnt_w(NUM_DIGITS);
    localparam int unsigned FailW  = fail_cnt_w(MAX_ATTEMPTS);
    localparam int unsigned UserW  = idx_w(NUM_USERS);
    localparam int unsigned TimerW = timer_w(LOCKOUT_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned PwW    = NUM_DIGITS * KEY_W;

    // Digit 0 (first key entered) lives in the most significant nibble.
    typedef logic [NUM_DIGITS-1:0][KEY_W-1:0] pw_t;

    state_e            state_q, state_d;
    logic [DigitW-1:0] digit_cnt_q, digit_cnt_d;
    logic [FailW-1:0]  fail_cnt_q, fail_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic [UserW-1:0]  user_q, user_d;
    logic              chg_q, chg_d;
    logic              security_q, security_d;
    logic              buzzer_q, buzzer_d;
    logic              pw_changed_q, pw_changed_d;
    pw_t               shadow_q, shadow_d;
    pw_t               slot_q [NUM_USERS];
    pw_t               slot_d [NUM_USERS];

    logic              lock_load, lock_done;
    logic [DigitW-1:0] digit_idx, digit_cnt_next;
    logic              last_digit;
    logic [UserW-1:0]  user_cur;
    logic              digit_miss;

    // Per-key helpers: stored digit position, wrap of the digit counter, single-digit compare.
    always_comb begin
        digit_idx      = DigitW'(NUM_DIGITS - 1) - digit_cnt_q;
        last_digit     = (digit_cnt_q == DigitW'(NUM_DIGITS - 1));
        digit_cnt_next = last_digit ? '0 : digit_cnt_q + DigitW'(1);
        // The slot is chosen live only on the first key; later keys use the latched user.
        user_cur       = (state_q == StIdle) ? kp.user_sel : user_q;
        digit_miss     = (kp.key_code != slot_q[user_cur][digit_idx]);
    end

    sha_lockout_timer #(
        .W (TimerW)
    ) u_lockout_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (lock_load),
        .load_val_i (TimerW'(LOCKOUT_CYCLES - 1)),
        .done_o     (lock_done)
    );

`ifdef INTER_KEY_TIMEOUT_EN
    logic to_load, to_done;

    // Reload on every accepted key and when entering CHG_NEW from CHECK.
    assign to_load = (kp.key_valid && (state_q inside {StIdle, StEntry, StChgOld, StChgNew}))
                     || (state_q == StCheck);

    sha_lockout_timer #(
        .W (TimerW)
    ) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (to_load),
        .load_val_i (TimerW'(TIMEOUT_CYCLES - 1)),
        .done_o     (to_done)
    );
`endif

    // Next-state, counters and slot update.
    always_comb begin
        state_d      = state_q;
        digit_cnt_d  = digit_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        mismatch_d   = mismatch_q;
        user_d       = user_q;
        chg_d        = chg_q;
        security_d   = security_q;
        buzzer_d     = buzzer_q;
        pw_changed_d = 1'b0;
        shadow_d     = shadow_q;
        slot_d       = slot_q;
        lock_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (kp.key_valid) begin
                    user_d      = kp.user_sel;
                    chg_d       = kp.change_mode;
                    mismatch_d  = digit_miss;
                    digit_cnt_d = digit_cnt_next;
                    if (last_digit) begin
                        state_d = StCheck;
                    end else begin
                        state_d = kp.change_mode ? StChgOld : StEntry;
                    end
                end
            end
            StEntry, StChgOld: begin
                if (kp.key_valid) begin
                    mismatch_d  = mismatch_q | digit_miss;
                    digit_cnt_d = digit_cnt_next;
                    if (last_digit) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                mismatch_d = 1'b0;
                if (!mismatch_q) begin
                    fail_cnt_d = '0;
                    if (chg_q) begin
                        state_d = StChgNew;
                    end else begin
                        security_d = ~security_q;
                        state_d    = StIdle;
                    end
                end else if (fail_cnt_q == FailW'(MAX_ATTEMPTS - 1)) begin
                    fail_cnt_d = FailW'(MAX_ATTEMPTS);
                    buzzer_d   = 1'b1;
                    lock_load  = 1'b1;
                    state_d    = StLockout;
                end else begin
                    fail_cnt_d = fail_cnt_q + FailW'(1);
                    state_d    = StIdle;
                end
            end
            StChgNew: begin
                if (kp.key_valid) begin
                    shadow_d[digit_idx] = kp.key_code;
                    digit_cnt_d         = digit_cnt_next;
                    if (last_digit) begin
                        // Whole new code committed at once from the completed buffer.
                        slot_d[user_q] = shadow_d;
                        pw_changed_d   = 1'b1;
                        state_d        = StIdle;
                    end
                end
            end
            StLockout: begin
                if (lock_done) begin
                    fail_cnt_d = '0;
                    buzzer_d   = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef INTER_KEY_TIMEOUT_EN
        // Stalled partial entry: drop it silently, no failure counted.
        if ((state_q inside {StEntry, StChgOld, StChgNew}) && !kp.key_valid && to_done) begin
            state_d     = StIdle;
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            shadow_d    = '0;
        end
`endif
    end

    // State and storage registers; reset restores the default passwords.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            user_q       <= '0;
            chg_q        <= 1'b0;
            security_q   <= 1'b0;
            buzzer_q     <= 1'b0;
            pw_changed_q <= 1'b0;
            shadow_q     <= '0;
            for (int u = 0; u < NUM_USERS; u++) begin
                slot_q[u] <= pw_t'(DEFAULT_PW[u*PwW +: PwW]);
            end
        end else begin
            state_q      <= state_d;
            digit_cnt_q  <= digit_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            mismatch_q   <= mismatch_d;
            user_q       <= user_d;
            chg_q        <= chg_d;
            security_q   <= security_d;
            buzzer_q     <= buzzer_d;
            pw_changed_q <= pw_changed_d;
            shadow_q     <= shadow_d;
            for (int u = 0; u < NUM_USERS; u++) begin
                slot_q[u] <= slot_d[u];
            end
        end
    end

    assign kp.security_active = security_q;
    assign kp.locked_out      = (state_q == StLockout);
    assign kp.buzzer          = buzzer_q;
    assign kp.auth_ok         = (state_q == StCheck) && !mismatch_q;
    assign kp.auth_fail       = (state_q == StCheck) && mismatch_q;
    assign kp.pw_changed      = pw_changed_q;
    assign kp.attempts_left   = FailW'(MAX_ATTEMPTS) - fail_cnt_q;
    assign kp.busy            = (state_q != StIdle);

endmodule

// File: tb/tb_sha_keypad_auth.sv
// Directed bench for sha_keypad_auth: 4-digit codes, 2 users, 3 attempts, 100-cycle lockout.
module tb_sha_keypad_auth;
    import sha_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic exp_sec;
    int   lock_cyc;
    logic saw_ok;

    sha_keypad_auth_if #(
        .KEY_W        (4),
        .NUM_USERS    (2),
        .MAX_ATTEMPTS (3)
    ) kp ();

    sha_keypad_auth #(
        .NUM_DIGITS     (4),
        .KEY_W          (4),
        .NUM_USERS      (2),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (100),
        .DEFAULT_PW     ({2{16'h1234}}),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input key_code_t k);
        @(negedge clk);
        kp.key_valid = 1'b1;
        kp.key_code  = k;
        @(negedge clk);
        kp.key_valid = 1'b0;
    endtask

    // Four digits, MS nibble first; user_sel/change_mode flipped after the first key.
    task automatic enter(input logic u, input logic chg, input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            kp.user_sel    = (i == 0) ? u : ~u;
            kp.change_mode = (i == 0) ? chg : ~chg;
            press(code[15-4*i -: 4]);
        end
        kp.user_sel    = 1'b0;
        kp.change_mode = 1'b0;
    endtask

    // Enter a code, check the CHECK-cycle pulses, then the arm flag one cycle later.
    task automatic try_code(input logic u, input logic chg, input logic [15:0] code,
                            input logic good, input string tag);
        enter(u, chg, code);
        chk({tag, ".auth_ok"}, 32'(kp.auth_ok), 32'(good));
        chk({tag, ".auth_fail"}, 32'(kp.auth_fail), 32'(!good));
        @(negedge clk);
        if (good && !chg) exp_sec = ~exp_sec;
        chk({tag, ".security"}, 32'(kp.security_active), 32'(exp_sec));
        chk({tag, ".pulse_gone"}, 32'(kp.auth_ok | kp.auth_fail), 32'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".security"}, 32'(kp.security_active), 32'(0));
        chk({tag, ".locked"}, 32'(kp.locked_out), 32'(0));
        chk({tag, ".buzzer"}, 32'(kp.buzzer), 32'(0));
        chk({tag, ".auth_ok"}, 32'(kp.auth_ok), 32'(0));
        chk({tag, ".auth_fail"}, 32'(kp.auth_fail), 32'(0));
        chk({tag, ".pw_changed"}, 32'(kp.pw_changed), 32'(0));
        chk({tag, ".attempts"}, 32'(kp.attempts_left), 32'(3));
        chk({tag, ".busy"}, 32'(kp.busy), 32'(0));
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        exp_sec        = 1'b0;
        reset          = 1'b0;
        kp.key_valid   = 1'b0;
        kp.key_code    = '0;
        kp.user_sel    = '0;
        kp.change_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);

        // Correct code arms, then disarms; a key strobe during CHECK is dropped.
        try_code(1'b0, 1'b0, 16'h1234, 1'b1, "arm");
        enter(1'b0, 1'b0, 16'h1234);
        chk("disarm.auth_ok", 32'(kp.auth_ok), 32'(1));
        kp.key_valid = 1'b1;
        kp.key_code  = 4'h1;
        @(negedge clk);
        kp.key_valid = 1'b0;
        exp_sec = ~exp_sec;
        chk("disarm.security", 32'(kp.security_active), 32'(exp_sec));
        chk("check_drop.busy", 32'(kp.busy), 32'(0));

        // Three failures lead to a 100-cycle lockout that ignores keys.
        try_code(1'b0, 1'b0, 16'h1235, 1'b0, "fail1");
        chk("fail1.attempts", 32'(kp.attempts_left), 32'(2));
        try_code(1'b0, 1'b0, 16'h1235, 1'b0, "fail2");
        chk("fail2.attempts", 32'(kp.attempts_left), 32'(1));
        try_code(1'b0, 1'b0, 16'h1235, 1'b0, "fail3");
        chk("fail3.attempts", 32'(kp.attempts_left), 32'(0));
        chk("fail3.locked", 32'(kp.locked_out), 32'(1));
        chk("fail3.buzzer", 32'(kp.buzzer), 32'(1));
        lock_cyc = 0;
        saw_ok   = 1'b0;
        while (kp.locked_out && lock_cyc < 200) begin
            lock_cyc++;
            kp.key_valid = (lock_cyc % 2 == 1) && (lock_cyc < 9);
            kp.key_code  = 4'((lock_cyc + 1) / 2);
            @(negedge clk);
            saw_ok = saw_ok | kp.auth_ok | kp.auth_fail;
        end
        kp.key_valid = 1'b0;
        chk("lockout.cycles", 32'(lock_cyc), 32'(100));
        chk("lockout.keys_ignored", 32'(saw_ok), 32'(0));
        chk("lockout.buzzer_off", 32'(kp.buzzer), 32'(0));
        chk("lockout.attempts", 32'(kp.attempts_left), 32'(3));
        chk("lockout.busy", 32'(kp.busy), 32'(0));
        try_code(1'b0, 1'b0, 16'h1234, 1'b1, "post_lock");

        // Password change for user 0: 1234 -> 9876.
        try_code(1'b0, 1'b1, 16'h1234, 1'b1, "chg_old");
        chk("chg_old.busy", 32'(kp.busy), 32'(1));
        enter(1'b0, 1'b0, 16'h9876);
        chk("chg_new.pw_changed", 32'(kp.pw_changed), 32'(1));
        chk("chg_new.busy", 32'(kp.busy), 32'(0));
        @(negedge clk);
        chk("chg_new.pulse_gone", 32'(kp.pw_changed), 32'(0));
        try_code(1'b0, 1'b0, 16'h1234, 1'b0, "old_pw");
        chk("old_pw.attempts", 32'(kp.attempts_left), 32'(2));
        try_code(1'b0, 1'b0, 16'h9876, 1'b1, "new_pw");
        chk("new_pw.attempts", 32'(kp.attempts_left), 32'(3));
        try_code(1'b1, 1'b0, 16'h1234, 1'b1, "user1");

        // Change attempt with a wrong old code leaves the slot alone.
        try_code(1'b0, 1'b1, 16'h1111, 1'b0, "chg_bad");
        chk("chg_bad.attempts", 32'(kp.attempts_left), 32'(2));
        chk("chg_bad.busy", 32'(kp.busy), 32'(0));
        try_code(1'b0, 1'b0, 16'h9876, 1'b1, "chg_bad_kept");

        // Reset on the third new digit restores default passwords.
        try_code(1'b0, 1'b1, 16'h9876, 1'b1, "chg2_old");
        press(4'h5);
        press(4'h5);
        press(4'h5);
        reset = 1'b0;
        #1;
        exp_sec = 1'b0;
        chk_reset_vals("rst_chg");
        @(negedge clk);
        reset = 1'b1;
        try_code(1'b0, 1'b0, 16'h1234, 1'b1, "rst_chg_default");

        // Reset in the middle of a lockout.
        try_code(1'b0, 1'b0, 16'h4321, 1'b0, "lk_fail1");
        try_code(1'b0, 1'b0, 16'h4321, 1'b0, "lk_fail2");
        try_code(1'b0, 1'b0, 16'h4321, 1'b0, "lk_fail3");
        repeat (20) @(negedge clk);
        chk("mid_lock.locked", 32'(kp.locked_out), 32'(1));
        reset = 1'b0;
        #1;
        exp_sec = 1'b0;
        chk_reset_vals("rst_lock");
        @(negedge clk);
        reset = 1'b1;
        try_code(1'b0, 1'b0, 16'h1234, 1'b1, "rst_lock_default");

`ifdef INTER_KEY_TIMEOUT_EN
        // Partial entry abandoned by the inter-key timeout.
        press(4'h1);
        press(4'h2);
        repeat (60) @(negedge clk);
        chk("timeout.busy", 32'(kp.busy), 32'(0));
        try_code(1'b0, 1'b0, 16'h1234, 1'b1, "timeout");
        chk("timeout.attempts", 32'(kp.attempts_left), 32'(3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha_keypad_auth.md
Name: sha_keypad_auth

Overview:
Parametrised keypad authentication controller for the smart-home top level, replacing the fixed 10-key, single-password login. It takes debounced keypad strobes and checks N-digit codes against per-user stored passwords. It toggles the security arm state, enforces lockout after repeated failures, and supports a verified password change. It feeds `security_active` and the lockout buzzer to the alarm and comfort logic.

Parameters:
- NUM_DIGITS, 10: digits per password.
- KEY_W, 4: bits per key code.
- NUM_USERS, 2: stored password slots.
- MAX_ATTEMPTS, 3: consecutive failures before lockout.
- LOCKOUT_CYCLES, 30_000_000: lockout duration in clk cycles.
- DEFAULT_PW, {NUM_USERS{40'h123456789A}}: reset value of all slots, packed with slot 0 in the LSBs.
- TIMEOUT_CYCLES, 5_000_000: inter-key timeout. Used only with INTER_KEY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  single-cycle strobe marking one debounced key.
- key_code  in  KEY_W  key value, sampled when key_valid=1.
- user_sel  in  clog2(NUM_USERS)  slot select, latched on the first key of an entry.
- change_mode  in  1  sampled on the first key; 1 starts a password-change sequence.
- security_active  out  1  armed flag; toggled by each correct code.
- locked_out  out  1  high while in LOCKOUT.
- buzzer  out  1  lockout buzzer.
- auth_ok  out  1  1-cycle pulse on a correct code.
- auth_fail  out  1  1-cycle pulse on a wrong code.
- pw_changed  out  1  1-cycle pulse when a new password is committed.
- attempts_left  out  clog2(MAX_ATTEMPTS+1)  MAX_ATTEMPTS minus fail_cnt.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asserted asynchronously):
  - All outputs 0, except attempts_left=MAX_ATTEMPTS.
  - State=IDLE; digit_cnt=0; fail_cnt=0; mismatch=0.
  - All slots = DEFAULT_PW.
- Comparison is incremental, one digit per key: mismatch |= (key_code != slot[user][digit_cnt]). There is no wide comparator.
- IDLE:
  - key_valid latches user_sel and change_mode, processes digit 0, and sets digit_cnt=1.
  - Next state is ENTRY, or CHG_OLD if change_mode=1.
- ENTRY / CHG_OLD:
  - Each key_valid processes one digit.
  - After the NUM_DIGITS-th key, the next state is CHECK.
- CHECK (exactly 1 cycle, entered the cycle after the last key):
  - Match, from ENTRY: security_active toggles, auth_ok pulses, fail_cnt=0, next state IDLE.
  - Match, from CHG_OLD: auth_ok pulses, fail_cnt=0, next state CHG_NEW. security_active is unchanged.
  - Mismatch: auth_fail pulses and fail_cnt increments.
    - If fail_cnt reaches MAX_ATTEMPTS: next state LOCKOUT, buzzer=1, timer=LOCKOUT_CYCLES-1.
    - Otherwise: next state IDLE.
- CHG_NEW:
  - Keys fill a shadow buffer of NUM_DIGITS x KEY_W.
  - On the NUM_DIGITS-th key, the buffer is written to slot[user] in one cycle, pw_changed pulses, and the next state is IDLE.
  - The slot is never partially written.
- LOCKOUT:
  - All key_valid are ignored.
  - The timer decrements each cycle. At 0: next state IDLE, fail_cnt=0, buzzer=0, locked_out=0.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- key_valid arriving in CHECK is dropped.
- user_sel and change_mode changes mid-entry are ignored.
- Wrap: digit_cnt never exceeds NUM_DIGITS-1. The timer saturates at 0.
- Reset mid-entry or mid-lockout aborts immediately to reset values, including restoring DEFAULT_PW.
- Latency: auth_ok/auth_fail assert 1 cycle after the final key strobe.

Optional Feature:
INTER_KEY_TIMEOUT_EN
- Defined: in ENTRY, CHG_OLD or CHG_NEW, a counter reloads on each key.
  - If TIMEOUT_CYCLES elapse with no key, the entry is aborted to IDLE and the shadow buffer is discarded.
  - A timeout does not count as a failure and produces no pulse.
- Undefined: a partial entry waits indefinitely. The counter logic is absent.

Decomposition:
- Package sha_pkg holds:
  - the state enum (IDLE, ENTRY, CHG_OLD, CHECK, CHG_NEW, LOCKOUT);
  - the key-code typedef `logic [KEY_W-1:0]`;
  - the localparam widths for digit_cnt, fail_cnt and the timer.
- One sub-module, sha_lockout_timer: a loadable down-counter with a `done` flag, reused for the lockout and the optional timeout.

Test Plan:
(Bench uses NUM_DIGITS=4, KEY_W=4, NUM_USERS=2, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=100, DEFAULT_PW 16'h1234 per slot.)
- Correct code: user 0 enters 1,2,3,4 → auth_ok 1 cycle after the last strobe, security_active 0→1. Repeating the entry gives 1→0.
- Three failures: enter 1,2,3,5 three times → attempts_left 3→2→1→0. After the third, locked_out=1 and buzzer=1. Keys during lockout are ignored. Both drop after exactly 100 cycles, and attempts_left returns to 3.
- Password change: change_mode=1, enter 1,2,3,4 then 9,8,7,6 → pw_changed pulse. After that, 1,2,3,4 gives auth_fail and 9,8,7,6 gives auth_ok. User 1 still accepts 1,2,3,4.
- Change with wrong old code: 1,1,1,1 → auth_fail, attempts_left=2, slot unchanged.
- Reset on the 3rd digit of a change-new entry, or mid-lockout → all outputs at reset values, and slot 0 accepts 1,2,3,4 again.
- With INTER_KEY_TIMEOUT_EN (TIMEOUT_CYCLES=50): enter 1,2, idle 60 cycles, then 1,2,3,4 → auth_ok, attempts_left stays 3.
